// File: rtl/sap_reg_bank.sv
// SAP general-purpose register bank: one in-place operation or bus load per clock,
// a combinational tristate read port, and registered carry/zero flags for branching.
module sap_reg_bank #(
  parameter int WIDTH  = 4,
  parameter int NREGS  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              async_reset,
  input  logic [WIDTH-1:0]  bus_in,
  output logic [WIDTH-1:0]  bus_out,
  input  logic              low_i_en,
  input  logic              low_o_en,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic [ADDR_W-1:0] rd_sel,
  input  logic [2:0]        op,
  input  logic              ser_in,
  output logic              carry,
  output logic              zero
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_DEC  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;

  localparam logic [ADDR_W:0] NREGS_L = (ADDR_W + 1)'(NREGS);

  logic [WIDTH-1:0] regs [NREGS];
  logic             wr_ok;
  logic             rd_ok;
  logic [WIDTH-1:0] cur;
  logic [WIDTH:0]   nxt;
  logic [WIDTH-1:0] rd_val;

  // Result packed as {carry, value}; the extra MSB of INC/DEC is the carry/borrow.
  function automatic logic [WIDTH:0] alu(input logic [2:0]       f_op,
                                         input logic [WIDTH-1:0] r,
                                         input logic [WIDTH-1:0] b,
                                         input logic             s);
    logic [WIDTH:0] res;
    unique case (f_op)
      OP_LOAD: res = {1'b0, b};
      OP_INC:  res = {1'b0, r} + (WIDTH + 1)'(1);
      OP_DEC:  res = {1'b0, r} - (WIDTH + 1)'(1);
      OP_SHL:  res = {r, s};
      OP_SHR:  res = {r[0], s, r[WIDTH-1:1]};
      OP_ROL:  res = {r[WIDTH-1], r[WIDTH-2:0], r[WIDTH-1]};
      OP_ROR:  res = {r[0], r[0], r[WIDTH-1:1]};
      default: res = '0;
    endcase
    return res;
  endfunction

  always_comb begin
    wr_ok = 1'b0;
    cur   = '0;
    if (!low_i_en && ({1'b0, wr_sel} < NREGS_L)) begin
      wr_ok = 1'b1;
      cur   = regs[wr_sel];
    end
    nxt = alu(op, cur, bus_in, ser_in);
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      carry <= 1'b0;
      zero  <= 1'b1;
    end else if (wr_ok) begin
      regs[wr_sel] <= nxt[WIDTH-1:0];
      carry        <= nxt[WIDTH];
      zero         <= (nxt[WIDTH-1:0] == '0);
    end
  end

  // Out-of-range read selects drive zeros rather than floating the bus.
  always_comb begin
    rd_ok  = ({1'b0, rd_sel} < NREGS_L);
    rd_val = '0;
    if (rd_ok) rd_val = regs[rd_sel];
  end

  assign bus_out = low_o_en ? {WIDTH{1'bz}} : rd_val;

endmodule

// File: tb/tb_sap_reg_bank.sv
// Directed bench for sap_reg_bank: vector table for single-edge operations, hand
// sequences for reset, tristate release, ignored writes and register moves.
module tb_sap_reg_bank;

  logic       clk = 1'b0;
  logic       async_reset = 1'b1;
  logic [3:0] bus_drv = 4'h0;
  logic       loop = 1'b0;
  logic       low_i_en = 1'b1;
  logic       low_o_en = 1'b1;
  logic       ser_in = 1'b0;
  logic [1:0] wr_sel = 2'd0;
  logic [1:0] rd_sel = 2'd0;
  logic [2:0] op = 3'd0;
  wire  [3:0] bus_w;
  wire  [3:0] bus3_w;
  wire  [3:0] bus_in_w;
  logic       carry, zero, carry3, zero3;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  assign bus_in_w = loop ? bus_w : bus_drv;

  for (genvar g = 0; g < 4; g++) begin : g_pu
    pullup (bus_w[g]);
    pullup (bus3_w[g]);
  end

  sap_reg_bank #(.WIDTH(4), .NREGS(4), .ADDR_W(2)) dut (
    .clk(clk), .async_reset(async_reset), .bus_in(bus_in_w), .bus_out(bus_w),
    .low_i_en(low_i_en), .low_o_en(low_o_en), .wr_sel(wr_sel), .rd_sel(rd_sel),
    .op(op), .ser_in(ser_in), .carry(carry), .zero(zero)
  );

  sap_reg_bank #(.WIDTH(4), .NREGS(3), .ADDR_W(2)) dut3 (
    .clk(clk), .async_reset(async_reset), .bus_in(bus_in_w), .bus_out(bus3_w),
    .low_i_en(low_i_en), .low_o_en(low_o_en), .wr_sel(wr_sel), .rd_sel(rd_sel),
    .op(op), .ser_in(ser_in), .carry(carry3), .zero(zero3)
  );

  typedef struct {
    logic [2:0] op;
    logic [1:0] ws;
    logic       lie;
    logic [3:0] bin;
    logic       ser;
    logic [1:0] rs;
    logic [3:0] eb;
    logic       ec;
    logic       ez;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // LOAD=0 INC=1 DEC=2 SHL=3 SHR=4 ROL=5 ROR=6 CLR=7
    vt[0]  = '{3'd0, 2'd2, 1'b0, 4'h5, 1'b0, 2'd2, 4'h5, 1'b0, 1'b0};
    vt[1]  = '{3'd0, 2'd1, 1'b0, 4'hF, 1'b0, 2'd1, 4'hF, 1'b0, 1'b0};
    vt[2]  = '{3'd1, 2'd1, 1'b0, 4'h0, 1'b0, 2'd1, 4'h0, 1'b1, 1'b1};
    vt[3]  = '{3'd2, 2'd1, 1'b0, 4'h0, 1'b0, 2'd1, 4'hF, 1'b1, 1'b0};
    vt[4]  = '{3'd2, 2'd1, 1'b0, 4'h0, 1'b0, 2'd1, 4'hE, 1'b0, 1'b0};
    vt[5]  = '{3'd0, 2'd0, 1'b0, 4'h9, 1'b0, 2'd0, 4'h9, 1'b0, 1'b0};
    vt[6]  = '{3'd3, 2'd0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h2, 1'b1, 1'b0};
    vt[7]  = '{3'd6, 2'd0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h1, 1'b0, 1'b0};
    vt[8]  = '{3'd4, 2'd0, 1'b0, 4'h0, 1'b1, 2'd0, 4'h8, 1'b1, 1'b0};
    vt[9]  = '{3'd5, 2'd0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h1, 1'b1, 1'b0};
    vt[10] = '{3'd7, 2'd0, 1'b1, 4'h0, 1'b0, 2'd0, 4'h1, 1'b1, 1'b0};
    vt[11] = '{3'd7, 2'd0, 1'b1, 4'h0, 1'b0, 2'd0, 4'h1, 1'b1, 1'b0};
    vt[12] = '{3'd7, 2'd0, 1'b1, 4'h0, 1'b0, 2'd0, 4'h1, 1'b1, 1'b0};
    vt[13] = '{3'd3, 2'd0, 1'b0, 4'h0, 1'b1, 2'd0, 4'h3, 1'b0, 1'b0};
    vt[14] = '{3'd4, 2'd0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h1, 1'b1, 1'b0};
    vt[15] = '{3'd7, 2'd0, 1'b0, 4'h0, 1'b0, 2'd2, 4'h5, 1'b0, 1'b1};
    vt[16] = '{3'd0, 2'd3, 1'b0, 4'h7, 1'b0, 2'd3, 4'h7, 1'b0, 1'b0};

    #2 async_reset = 1'b0;
    low_o_en = 1'b0;

    // Preload every register with A, then reset between edges.
    for (int r = 0; r < 4; r++) begin
      op = 3'd0; wr_sel = 2'(r); bus_drv = 4'hA; low_i_en = 1'b0;
      step();
    end
    for (int r = 0; r < 4; r++) begin
      rd_sel = 2'(r); #1;
      chk($sformatf("preload_r%0d", r), 8'(bus_w), 8'hA);
    end
    chk("preload_zero", 8'(zero), 8'h0);
    #1 async_reset = 1'b1;
    #1;
    chk("rst_carry", 8'(carry), 8'h0);
    chk("rst_zero", 8'(zero), 8'h1);
    for (int r = 0; r < 4; r++) begin
      rd_sel = 2'(r); #1;
      chk($sformatf("rst_r%0d", r), 8'(bus_w), 8'h0);
    end
    op = 3'd0; wr_sel = 2'd1; bus_drv = 4'h5; low_i_en = 1'b0; rd_sel = 2'd1;
    step();
    step();
    chk("rst_hold_bus", 8'(bus_w), 8'h0);
    chk("rst_hold_zero", 8'(zero), 8'h1);
    async_reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      op = vt[i].op; wr_sel = vt[i].ws; low_i_en = vt[i].lie; bus_drv = vt[i].bin;
      ser_in = vt[i].ser; rd_sel = vt[i].rs; low_o_en = 1'b0;
      step();
      chk($sformatf("v%0d_bus", i), 8'(bus_w), 8'(vt[i].eb));
      chk($sformatf("v%0d_carry", i), 8'(carry), 8'(vt[i].ec));
      chk($sformatf("v%0d_zero", i), 8'(zero), 8'(vt[i].ez));
    end

    // Released bus floats up to the pull-ups; reg2 holds 5.
    low_i_en = 1'b1; rd_sel = 2'd2; low_o_en = 1'b1; #1;
    chk("tri_off", 8'(bus_w), 8'hF);
    low_o_en = 1'b0; #1;
    chk("tri_on", 8'(bus_w), 8'h5);

    // Three-register bank ignores wr_sel=3 and reads zeros there.
    low_i_en = 1'b0; op = 3'd0; wr_sel = 2'd1; bus_drv = 4'h6; step();
    wr_sel = 2'd2; bus_drv = 4'hF; step();
    op = 3'd1; step();
    chk("n3_inc_carry", 8'(carry3), 8'h1);
    chk("n3_inc_zero", 8'(zero3), 8'h1);
    op = 3'd0; wr_sel = 2'd3; bus_drv = 4'h5;
    for (int k = 0; k < 3; k++) step();
    chk("n3_ign_carry", 8'(carry3), 8'h1);
    chk("n3_ign_zero", 8'(zero3), 8'h1);
    rd_sel = 2'd1; #1;
    chk("n3_r1", 8'(bus3_w), 8'h6);
    rd_sel = 2'd3; #1;
    chk("n3_rd_oor", 8'(bus3_w), 8'h0);
    chk("n4_r3", 8'(bus_w), 8'h5);
    chk("n4_zero", 8'(zero), 8'h0);

    // Register move over the looped bus.
    wr_sel = 2'd3; bus_drv = 4'h7; op = 3'd0; step();
    loop = 1'b1; rd_sel = 2'd3; wr_sel = 2'd0; op = 3'd0; #1;
    chk("mv_src_before", 8'(bus_w), 8'h7);
    step();
    chk("mv_src_after", 8'(bus_w), 8'h7);
    rd_sel = 2'd0; #1;
    chk("mv_dst", 8'(bus_w), 8'h7);

    // Same move aborted by a reset ahead of the edge.
    wr_sel = 2'd3; loop = 1'b0; bus_drv = 4'h9; step();
    loop = 1'b1; rd_sel = 2'd3; wr_sel = 2'd0;
    #2 async_reset = 1'b1;
    #1;
    chk("mvrst_src", 8'(bus_w), 8'h0);
    step();
    async_reset = 1'b0; low_i_en = 1'b1; loop = 1'b0;
    rd_sel = 2'd0; #1;
    chk("mvrst_dst", 8'(bus_w), 8'h0);
    chk("mvrst_zero", 8'(zero), 8'h1);
    chk("mvrst_carry", 8'(carry), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sap_reg_bank.md
Name: sap_reg_bank

Overview:
- Parametrised bank of NREGS general-purpose registers, each WIDTH bits, for the SAP datapath.
- Each cycle, one register may be written from the shared bus or modified in place: increment, decrement, shift, rotate or clear.
- One register can be driven onto the shared tristate bus.
- Registered carry and zero flags feed the controller's conditional-jump logic.

Parameters:
- WIDTH, 4, data width of each register and of the bus.
- NREGS, 4, number of registers in the bank.
- ADDR_W, 2, select width; 2**ADDR_W must be >= NREGS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- async_reset  input  1  asynchronous, active-high reset.
- bus_in  input  WIDTH  data from the shared bus, used by LOAD.
- bus_out  output  WIDTH  tristate bus drive.
- low_i_en  input  1  write/operate enable, active low.
- low_o_en  input  1  bus output enable, active low.
- wr_sel  input  ADDR_W  index of the register to write or operate on.
- rd_sel  input  ADDR_W  index of the register driven onto bus_out.
- op  input  3  operation code, used when low_i_en=0.
- ser_in  input  1  serial fill bit for SHL/SHR.
- carry  output  1  registered carry/borrow/shifted-out bit.
- zero  output  1  registered result-is-zero flag.

Behaviour:
- Reset:
  - async_reset=1 immediately clears all registers, carry=0 and zero=1, independent of clk.
  - Reset overrides every other input.
  - Reset asserted mid-operation discards that operation.
  - While reset is held, rising clk edges have no effect.
- Write qualification:
  - On a rising clk edge with async_reset=0, low_i_en=0 and wr_sel<NREGS, regs[wr_sel] <= result(op).
  - Carry and zero update in the same edge.
- Ignored edges: if low_i_en=1, or wr_sel>=NREGS, the registers and flags hold.
- op encoding, with R=regs[wr_sel], as result/carry:
  - 000 LOAD: R=bus_in; carry=0.
  - 001 INC: R=R+1 mod 2^WIDTH; carry=1 only when R was all ones, which wraps to 0.
  - 010 DEC: R=R-1 mod 2^WIDTH; carry (borrow)=1 only when R was 0, which wraps to all ones.
  - 011 SHL: R={R[WIDTH-2:0],ser_in}; carry=old R[WIDTH-1].
  - 100 SHR: R={ser_in,R[WIDTH-1:1]}; carry=old R[0].
  - 101 ROL: R={R[WIDTH-2:0],R[WIDTH-1]}; carry=old R[WIDTH-1].
  - 110 ROR: R={R[0],R[WIDTH-1:1]}; carry=old R[0].
  - 111 CLR: R=0; carry=0.
- Flags:
  - zero=1 iff the new value written is all zeros.
  - Flags reflect only the most recent qualified write.
- Read port:
  - Combinational, no latency.
  - low_o_en=0 and rd_sel<NREGS: bus_out=regs[rd_sel].
  - low_o_en=0 and rd_sel>=NREGS: bus_out=0.
  - low_o_en=1: bus_out=all Z.
- Simultaneous read/write of the same index:
  - bus_out shows the old value until the edge, then the new value.
  - Loading from bus_in while that bus is driven by bus_out of the same register is legal: a register-to-register move, or a self-load that leaves the value unchanged.
- Latency: one clk edge from enable to new register and flag values. No multi-cycle operations and no internal state beyond the registers and flags.

Test Plan:
1. Assert async_reset between clock edges with regs preloaded to 4'hA -> all regs read 0, carry=0, zero=1, with no clk edge needed; edges while reset is held change nothing.
2. LOAD 4'h5 into reg2 (op=000, wr_sel=2, low_i_en=0), then rd_sel=2, low_o_en=0 -> bus_out=4'h5, zero=0, carry=0. With low_o_en=1 -> bus_out=4'bzzzz.
3. Load reg1=4'hF, then INC -> reg1=4'h0, carry=1, zero=1. Then DEC -> reg1=4'hF, carry=1, zero=0. Then DEC -> reg1=4'hE, carry=0.
4. Load reg0=4'b1001:
   - SHL with ser_in=0 -> 4'b0010, carry=1.
   - Then ROR -> 4'b0001, carry=0.
   - Then SHR with ser_in=1 -> 4'b1000, carry=1.
   - Then ROL -> 4'b0001, carry=1.
5. With low_i_en=1, present op=CLR, wr_sel=0 for 3 edges -> reg0 and flags unchanged. Repeat with NREGS=3 and wr_sel=3 -> no register or flag changes.
6. Move: reg3=4'h7; rd_sel=3, low_o_en=0 with bus_out looped to bus_in; LOAD wr_sel=0 -> reg0=4'h7 after one edge, reg3 unchanged. Assert async_reset in the same cycle before the edge -> reg0=0, and no load occurs.
